// File: rtl/tone_osc_bank.sv
// Multi-channel square-wave tone bank: (octave, note) commands drive per-channel
// half-period oscillators whose +/-AMP outputs are summed into one signed stream.
// Optional macro TONE_GLIDE_EN enables portamento on retriggered active channels.
module tone_osc_bank #(
    parameter int CHANNELS = 4,
    parameter int AMP_W    = 24,
    parameter int AMP      = 2**20,
    parameter int OUT_W    = AMP_W + $clog2(CHANNELS),
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [CH_W-1:0]         cmd_chan,
    input  logic                    cmd_on,
    input  logic [2:0]              cmd_octave,
    input  logic [3:0]              cmd_note,
    output logic                    cmd_err,
    output logic [CHANNELS-1:0]     chan_active,
    output logic signed [OUT_W-1:0] mix_out
);

    localparam int PER_W = 20;
    localparam logic signed [AMP_W-1:0] AMP_C = AMP_W'(AMP);
    localparam logic signed [OUT_W-1:0] AMP_O = OUT_W'(AMP_C);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_LOAD} state_t;

    function automatic logic [PER_W-1:0] base_period(input logic [3:0] note);
        case (note)
            4'd0:    return 20'd909091;
            4'd1:    return 20'd858068;
            4'd2:    return 20'd809908;
            4'd3:    return 20'd764451;
            4'd4:    return 20'd721546;
            4'd5:    return 20'd681049;
            4'd6:    return 20'd642824;
            4'd7:    return 20'd606745;
            4'd8:    return 20'd572691;
            4'd9:    return 20'd540549;
            4'd10:   return 20'd510210;
            4'd11:   return 20'd481574;
            default: return '0;
        endcase
    endfunction

    function automatic logic [PER_W-1:0] half_m1(input logic [PER_W-1:0] p);
        return (p >> 1) - PER_W'(1);
    endfunction

`ifdef TONE_GLIDE_EN
    // One sixteenth of the remaining distance per toggle; a zero step snaps to target.
    function automatic logic [PER_W-1:0] glide_step(input logic [PER_W-1:0] cur,
                                                    input logic [PER_W-1:0] tgt);
        logic signed [PER_W:0] diff;
        logic signed [PER_W:0] step;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        step = diff >>> 4;
        if (step == '0)
            return tgt;
        return cur + step[PER_W-1:0];
    endfunction
`endif

    state_t              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                cmd_err_q, cmd_err_d;
    logic [CH_W-1:0]     chan_q, chan_d;
    logic                on_q, on_d;
    logic [2:0]          oct_q, oct_d;
    logic [3:0]          note_q, note_d;
    logic [PER_W-1:0]    per_l_q, per_l_d;
    logic                bad_q, bad_d;

    logic [PER_W-1:0]    period_q [CHANNELS];
    logic [PER_W-1:0]    period_d [CHANNELS];
    logic [PER_W-1:0]    count_q  [CHANNELS];
    logic [PER_W-1:0]    count_d  [CHANNELS];
`ifdef TONE_GLIDE_EN
    logic [PER_W-1:0]    target_q [CHANNELS];
    logic [PER_W-1:0]    target_d [CHANNELS];
`endif
    logic [CHANNELS-1:0] phase_q, phase_d;
    logic [CHANNELS-1:0] active_q, active_d;
    logic signed [OUT_W-1:0] mix_q, mix_d;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        cmd_err_d   = 1'b0;
        chan_d      = chan_q;
        on_d        = on_q;
        oct_d       = oct_q;
        note_d      = note_q;
        per_l_d     = per_l_q;
        bad_d       = bad_q;
        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    chan_d      = cmd_chan;
                    on_d        = cmd_on;
                    oct_d       = cmd_octave;
                    note_d      = cmd_note;
                    cmd_ready_d = 1'b0;
                    state_d     = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                per_l_d   = base_period(note_q) >> oct_q;
                bad_d     = (on_q && (note_q > 4'd11)) || (int'(chan_q) >= CHANNELS);
                cmd_err_d = bad_d;
                state_d   = S_LOAD;
            end
            S_LOAD: begin
                cmd_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Free-running oscillators; a LOAD to the same channel overrides the toggle.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            period_d[i] = period_q[i];
            count_d[i]  = count_q[i];
`ifdef TONE_GLIDE_EN
            target_d[i] = target_q[i];
`endif
            phase_d[i]  = phase_q[i];
            active_d[i] = active_q[i];
            if (active_q[i]) begin
                if (count_q[i] == '0) begin
                    phase_d[i] = ~phase_q[i];
`ifdef TONE_GLIDE_EN
                    period_d[i] = glide_step(period_q[i], target_q[i]);
`endif
                    count_d[i] = half_m1(period_d[i]);
                end else begin
                    count_d[i] = count_q[i] - PER_W'(1);
                end
            end
            if ((state_q == S_LOAD) && !bad_q && (int'(chan_q) == i)) begin
                if (on_q) begin
`ifdef TONE_GLIDE_EN
                    target_d[i] = per_l_q;
                    if (!active_q[i]) begin
                        period_d[i] = per_l_q;
                        count_d[i]  = half_m1(per_l_q);
                        phase_d[i]  = 1'b0;
                        active_d[i] = 1'b1;
                    end
`else
                    period_d[i] = per_l_q;
                    count_d[i]  = half_m1(per_l_q);
                    phase_d[i]  = 1'b0;
                    active_d[i] = 1'b1;
`endif
                end else begin
                    period_d[i] = period_q[i];
                    count_d[i]  = count_q[i];
                    phase_d[i]  = phase_q[i];
                    active_d[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        mix_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (active_q[i])
                mix_d = mix_d + (phase_q[i] ? -AMP_O : AMP_O);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            chan_q      <= '0;
            on_q        <= 1'b0;
            oct_q       <= '0;
            note_q      <= '0;
            per_l_q     <= '0;
            bad_q       <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                period_q[i] <= '0;
                count_q[i]  <= '0;
`ifdef TONE_GLIDE_EN
                target_q[i] <= '0;
`endif
            end
            phase_q     <= '0;
            active_q    <= '0;
            mix_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cmd_err_q   <= cmd_err_d;
            chan_q      <= chan_d;
            on_q        <= on_d;
            oct_q       <= oct_d;
            note_q      <= note_d;
            per_l_q     <= per_l_d;
            bad_q       <= bad_d;
            period_q    <= period_d;
            count_q     <= count_d;
`ifdef TONE_GLIDE_EN
            target_q    <= target_d;
`endif
            phase_q     <= phase_d;
            active_q    <= active_d;
            mix_q       <= mix_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign cmd_err     = cmd_err_q;
    assign chan_active = active_q;
    assign mix_out     = mix_q;

endmodule
